// File: rtl/x_uart_pkg.sv
// Shared types and constants for the x_uart serial blocks.
package x_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 104;

    // Width of a down-counter that must hold CLKS_PER_BIT-1.
    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/x_sync.sv
// Two-flop synchronizer for a single asynchronous input; RST_VAL sets the
// value both flops take in reset so an idle line looks idle out of reset.
module x_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/x_uart_rx.sv
// 8N1 UART receiver feeding the x_ctrl command decoder.
// Optional macro X_UART_RX_MAJORITY_EN: 2-of-3 vote around each mid-bit sample.
module x_uart_rx
    import x_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_frame_err
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = cnt_width(CLKS_PER_BIT);
`ifdef X_UART_RX_MAJORITY_EN
    localparam int MAJ_DLY = 1;
`else
    localparam int MAJ_DLY = 0;
`endif
    localparam logic [CW-1:0] START_LD = CW'(H + MAJ_DLY);
    localparam logic [CW-1:0] BIT_LD   = CW'(CLKS_PER_BIT - 1);

    logic          rx_s;
    logic          rx_p;
    logic          bit_in;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;

    x_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (i_clk),
        .rst_n (i_nrst),
        .d     (i_rx),
        .q     (rx_s)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) rx_p <= 1'b1;
        else         rx_p <= rx_s;
    end

`ifdef X_UART_RX_MAJORITY_EN
    // History of rx_s so that, one cycle after mid-bit, the vote window
    // covers mid-1, mid and mid+1; all sample points shift by one cycle.
    logic h0, h1;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            h0 <= 1'b1;
            h1 <= 1'b1;
        end else begin
            h0 <= rx_s;
            h1 <= h0;
        end
    end

    assign bit_in = (h1 & h0) | (h1 & rx_s) | (h0 & rx_s);
`else
    assign bit_in = rx_s;
`endif

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            o_valid     <= 1'b0;
            o_data      <= 8'h00;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Falling edge only: a line stuck low never re-triggers.
                    if (rx_p && !rx_s) begin
                        cnt   <= START_LD;
                        state <= START;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (!bit_in) begin
                        cnt   <= BIT_LD;
                        idx   <= '0;
                        state <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shreg <= {bit_in, shreg[7:1]};
                        cnt   <= BIT_LD;
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        if (bit_in) begin
                            o_valid <= 1'b1;
                            o_data  <= shreg;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
